// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: DMEM geometry, the
// read-return owner encoding and the default starvation limit.
package dmem_arbiter_pkg;

    localparam int ADDR_W           = 14;
    localparam int DATA_W           = 32;
    localparam int WE_W             = DATA_W / 8;
    localparam int STARVE_LIMIT_DEF = 8;

    // Which requester the DMEM read data of the current cycle belongs to.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } rd_owner_t;

    // A byte-enable vector of all zeros marks a read access.
    function automatic logic is_read(input logic [WE_W-1:0] wea);
        return (wea == '0);
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// starve_counter: saturating count of consecutive cycles a pending secondary
// request was refused. at_limit tells the arbiter to force the next grant.
// Only instantiated when DMEM_ARB_STARVE_EN is defined.
module dmem_arbiter_starve_counter #(
    parameter int LIMIT = 8,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    // Count refused cycles, stop at the limit, restart on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT_C)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DMEM between the CPU EX stage
// (priority) and a secondary requester (boot loader / DMA), and routes the
// one-cycle-late read data back to whoever issued the read.
// Optional feature macro: DMEM_ARB_STARVE_EN -- when defined, a starvation
// counter forces a grant to the secondary requester after STARVE_LIMIT
// refused cycles, stalling the CPU for that one cycle. When undefined the
// CPU has strict priority and cpu_stall is constant 0.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [13:0] cpu_addr,
    input  logic [3:0]  cpu_wea,
    input  logic [31:0] cpu_din,
    output logic        cpu_stall,
    output logic [31:0] cpu_dout,
    input  logic        dma_valid,
    output logic        dma_ready,
    input  logic [13:0] dma_addr,
    input  logic [3:0]  dma_wea,
    input  logic [31:0] dma_din,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [13:0] dmem_addra,
    output logic [3:0]  dmem_wea,
    output logic [31:0] dmem_dina,
    input  logic [31:0] dmem_douta
);

    // Parameter sanity folded into a signal so the tool sees the
    // parameters used in every build configuration.
    localparam bit CFG_OK = (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 255) &&
                            ((64'(1) << CNT_W) > 64'(STARVE_LIMIT));
    logic unused_cfg;
    assign unused_cfg = CFG_OK;

    logic        force_grant;
    logic        gnt_cpu;
    logic        gnt_dma;
    rd_owner_t   rd_owner;
    rd_owner_t   rd_owner_nxt;
    logic [31:0] cpu_dout_hold;

`ifdef DMEM_ARB_STARVE_EN
    logic at_limit;

    dmem_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (dma_valid && !dma_ready),
        .clr      (!dma_valid || dma_ready),
        .at_limit (at_limit)
    );

    assign force_grant = at_limit && dma_valid;
`else
    assign force_grant = 1'b0;
`endif

    // Grant decision: CPU first unless the starved secondary must go now.
    // Nothing is granted while reset is held.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dma = 1'b0;
        if (!rst) begin
            gnt_cpu = cpu_req && !force_grant;
            gnt_dma = dma_valid && (!cpu_req || force_grant);
        end
    end

    assign dma_ready = gnt_dma;

`ifdef DMEM_ARB_STARVE_EN
    assign cpu_stall = gnt_dma && cpu_req;
`else
    assign cpu_stall = 1'b0;
`endif

    // DMEM port mux: granted requester only, idle port driven to zero.
    always_comb begin
        dmem_addra = '0;
        dmem_wea   = '0;
        dmem_dina  = '0;
        if (gnt_cpu) begin
            dmem_addra = cpu_addr;
            dmem_wea   = cpu_wea;
            dmem_dina  = cpu_din;
        end else if (gnt_dma) begin
            dmem_addra = dma_addr;
            dmem_wea   = dma_wea;
            dmem_dina  = dma_din;
        end
    end

    // Read-return owner register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    // Next owner: whoever performs a read this cycle; writes get no response.
    always_comb begin
        rd_owner_nxt = NONE;
        if (gnt_cpu && is_read(cpu_wea)) begin
            rd_owner_nxt = CPU;
        end else if (gnt_dma && is_read(dma_wea)) begin
            rd_owner_nxt = DMA;
        end
    end

    // Keep the last CPU read word so cpu_dout holds between CPU reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_dout_hold <= '0;
        end else if (rd_owner == CPU) begin
            cpu_dout_hold <= dmem_douta;
        end
    end

    assign cpu_dout   = (rd_owner == CPU) ? dmem_douta : cpu_dout_hold;
    assign dma_rvalid = (rd_owner == DMA);
    assign dma_rdata  = dma_rvalid ? dmem_douta : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// mixed traffic, checked every cycle against a behavioural model with its
// own reference memory. Honours DMEM_ARB_STARVE_EN like the design.
module tb_dmem_arbiter;

    localparam int LIMIT = 8;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [13:0] cpu_addr;
    logic [3:0]  cpu_wea;
    logic [31:0] cpu_din;
    logic        cpu_stall;
    logic [31:0] cpu_dout;
    logic        dma_valid;
    logic        dma_ready;
    logic [13:0] dma_addr;
    logic [3:0]  dma_wea;
    logic [31:0] dma_din;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic [13:0] dmem_addra;
    logic [3:0]  dmem_wea;
    logic [31:0] dmem_dina;
    logic [31:0] dmem_douta = '0;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wea    (cpu_wea),
        .cpu_din    (cpu_din),
        .cpu_stall  (cpu_stall),
        .cpu_dout   (cpu_dout),
        .dma_valid  (dma_valid),
        .dma_ready  (dma_ready),
        .dma_addr   (dma_addr),
        .dma_wea    (dma_wea),
        .dma_din    (dma_din),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dmem_addra (dmem_addra),
        .dmem_wea   (dmem_wea),
        .dmem_dina  (dmem_dina),
        .dmem_douta (dmem_douta)
    );

    always #5 clk = ~clk;

    // The real single-port DMEM, synchronous read with 1-cycle latency.
    logic [31:0] mem [0:16383] = '{default: 32'h0};
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dmem_wea[b]) mem[dmem_addra][8*b +: 8] <= dmem_dina[8*b +: 8];
        end
        dmem_douta <= mem[dmem_addra];
    end

    // Behavioural model state.
    logic [31:0] ref_mem [0:16383] = '{default: 32'h0};
    int          wait_n;        // consecutive cycles a pending DMA request was refused
    int          pend_owner;    // 0 none, 1 cpu, 2 dma: read data due this cycle
    logic [31:0] pend_val;
    logic [31:0] exp_cpu_dout;
    logic        last_hs;       // model: DMA handshake happened last cycle
    logic        last_cstall;   // model: CPU was stalled last cycle
    logic        prev_dut_stall;

    // Observations of the last cycle for the directed literal checks.
    logic        obs_ready, obs_stall, obs_rvalid;
    logic [3:0]  obs_wea;
    logic [31:0] obs_rdata, obs_cpu_dout;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, then advance the model.
    task automatic cycle();
        logic        frc, g_cpu, g_dma;
        logic [13:0] e_addr;
        logic [3:0]  e_wea;
        logic [31:0] e_din;
        int          nxt_owner;
        logic [31:0] nxt_val;
        @(negedge clk);
        if (rst) begin
            pend_owner   = 0;
            exp_cpu_dout = '0;
            wait_n       = 0;
        end
        frc   = STARVE_ON && !rst && dma_valid && (wait_n == LIMIT);
        g_cpu = !rst && cpu_req && !frc;
        g_dma = !rst && dma_valid && (!cpu_req || frc);
        e_addr = g_cpu ? cpu_addr : (g_dma ? dma_addr : 14'h0);
        e_wea  = g_cpu ? cpu_wea  : (g_dma ? dma_wea  : 4'h0);
        e_din  = g_cpu ? cpu_din  : (g_dma ? dma_din  : 32'h0);
        if (pend_owner == 1) exp_cpu_dout = pend_val;

        chk("cpu_stall", cpu_stall, g_dma && cpu_req);
        chk("dma_ready", dma_ready, g_dma);
        chk("dmem_wea", dmem_wea, e_wea);
        chk("dmem_addra", dmem_addra, e_addr);
        chk("dmem_dina", dmem_dina, e_din);
        chk("dma_rvalid", dma_rvalid, pend_owner == 2);
        if (pend_owner == 2) chk("dma_rdata", dma_rdata, pend_val);
        chk("cpu_dout", cpu_dout, exp_cpu_dout);
        chk("stall_twice", prev_dut_stall & cpu_stall, 1'b0);

        prev_dut_stall = cpu_stall;
        obs_ready = dma_ready;  obs_stall = cpu_stall;  obs_rvalid = dma_rvalid;
        obs_wea = dmem_wea;     obs_rdata = dma_rdata;  obs_cpu_dout = cpu_dout;

        nxt_owner = (g_cpu && cpu_wea == 4'h0) ? 1 : ((g_dma && dma_wea == 4'h0) ? 2 : 0);
        nxt_val   = ref_mem[e_addr];
        for (int b = 0; b < 4; b++) begin
            if (e_wea[b]) ref_mem[e_addr][8*b +: 8] = e_din[8*b +: 8];
        end
        if (rst || g_dma || !dma_valid) wait_n = 0;
        else wait_n = wait_n + 1;
        last_hs     = g_dma;
        last_cstall = g_dma && cpu_req;
        @(posedge clk);
        pend_owner = nxt_owner;
        pend_val   = nxt_val;
        #1;
    endtask

    initial begin
        int served_at;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_addr = 14'h3; cpu_wea = 4'hF; cpu_din = 32'h11111111;
        dma_valid = 1'b1; dma_addr = 14'h4; dma_wea = 4'hF; dma_din = 32'h22222222;
        wait_n = 0; pend_owner = 0; pend_val = '0; exp_cpu_dout = '0;
        last_hs = 1'b0; last_cstall = 1'b0; prev_dut_stall = 1'b0;
        #1;

        // Reset state: nothing granted even with both requesting.
        cycle();
        chk("rst_stall", obs_stall, 1'b0);
        chk("rst_ready", obs_ready, 1'b0);
        chk("rst_wea", obs_wea, 4'h0);
        cpu_req = 1'b0; dma_valid = 1'b0;
        cycle();
        chk("rst_rvalid", obs_rvalid, 1'b0);
        chk("rst_cpu_dout", obs_cpu_dout, 32'h0);
        chk("rst_rdata", obs_rdata, 32'h0);
        rst = 1'b0;
        cycle();

        // CPU only: write then read back.
        cpu_req = 1'b1; cpu_addr = 14'h0010; cpu_wea = 4'hF; cpu_din = 32'hDEADBEEF;
        cycle();
        chk("cpu_wr_stall", obs_stall, 1'b0);
        cpu_wea = 4'h0;
        cycle();
        chk("cpu_rd_stall", obs_stall, 1'b0);
        cpu_req = 1'b0;
        cycle();
        chk("cpu_rd_data", obs_cpu_dout, 32'hDEADBEEF);

        // DMA while CPU idle: write then read back.
        dma_valid = 1'b1; dma_addr = 14'h0020; dma_wea = 4'hF; dma_din = 32'h12345678;
        cycle();
        chk("dma_wr_ready", obs_ready, 1'b1);
        dma_wea = 4'h0;
        cycle();
        chk("dma_rd_ready", obs_ready, 1'b1);
        dma_valid = 1'b0;
        cycle();
        chk("dma_rvalid_pulse", obs_rvalid, 1'b1);
        chk("dma_rd_data", obs_rdata, 32'h12345678);
        cycle();
        chk("dma_rvalid_end", obs_rvalid, 1'b0);

        // Starvation: CPU saturates the port while DMA waits.
        cpu_req = 1'b1; cpu_addr = 14'h0005; cpu_wea = 4'h0;
        dma_valid = 1'b1; dma_addr = 14'h0030; dma_wea = 4'hF; dma_din = 32'hA5A5A5A5;
        served_at = 0;
        for (int n = 1; n <= 20; n++) begin
            cycle();
            if (obs_ready) begin
                served_at = n;
                break;
            end
        end
`ifdef DMEM_ARB_STARVE_EN
        chk("starve_cycle", served_at, 9);
        chk("starve_stall", obs_stall, 1'b1);
        dma_addr = 14'h0031; dma_din = 32'h5A5A5A5A;
        cycle();
        chk("after_force_stall", obs_stall, 1'b0);
        chk("after_force_ready", obs_ready, 1'b0);
        cpu_req = 1'b0;
        cycle();
        chk("after_force_idle_ready", obs_ready, 1'b1);
`else
        chk("strict_no_grant", served_at, 0);
        cpu_req = 1'b0;
        cycle();
        chk("strict_grant_on_drop", obs_ready, 1'b1);
`endif
        dma_valid = 1'b0;
        cycle();

        // Reset during a pending DMA read.
        dma_valid = 1'b1; dma_addr = 14'h0020; dma_wea = 4'h0;
        cycle();
        chk("rr_hs", obs_ready, 1'b1);
        rst = 1'b1; dma_valid = 1'b0;
        cycle();
        chk("rr_rvalid", obs_rvalid, 1'b0);
        chk("rr_rdata", obs_rdata, 32'h0);
        chk("rr_cpu_dout", obs_cpu_dout, 32'h0);
        rst = 1'b0;
        cycle();
        chk("rr_rvalid_after", obs_rvalid, 1'b0);

        // Randomized mixed traffic with protocol-respecting requesters.
        for (int i = 0; i < 3000; i++) begin
            if (last_hs || !dma_valid) begin
                dma_valid = ($urandom_range(0, 2) != 0);
                dma_addr  = 14'($urandom_range(0, 15));
                dma_wea   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
                dma_din   = $urandom;
            end
            if (!last_cstall) begin
                cpu_req  = ($urandom_range(0, 3) != 0);
                cpu_addr = 14'($urandom_range(0, 15));
                cpu_wea  = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
                cpu_din  = $urandom;
            end
            cycle();
        end
        cpu_req = 1'b0; dma_valid = 1'b0;
        cycle();
        cycle();

        // Memory contents: no write lost or duplicated.
        for (int a = 0; a < 64; a++) begin
            chk("mem_final", mem[a], ref_mem[a]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
